// File: rtl/rv2t_uart_pkg.sv
// Shared definitions for the RV2T memory-mapped UART transmitter.
package rv2t_uart_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int ST_ACTIVE  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam int CT_EN    = 0;
    localparam int CT_FLUSH = 1;
    localparam int CT_STOP2 = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/rv2t_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, occupancy count and flush.
module rv2t_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_pop, do_push;

    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rv2t_uart_tx_mmio.sv
// Memory-mapped UART transmitter: register decode, TX FIFO, baud counter and frame FSM.
module rv2t_uart_tx_mmio
    import rv2t_uart_pkg::*;
#(
    parameter int                       MEM_ADDR_BITS   = 14,
    parameter logic [MEM_ADDR_BITS-1:0] BASE_WADDR      = 14'h3FF0,
    parameter int                       FIFO_DEPTH      = 8,
    parameter int                       DATA_BITS       = 8,
    parameter int                       BAUD_BITS       = 16,
    parameter logic [BAUD_BITS-1:0]     DEFAULT_BAUD_M1 = 16'd867
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync_reset,
    input  logic [MEM_ADDR_BITS-1:0] mem_addr,
    input  logic [3:0]               mem_write_en,
    input  logic [31:0]              mem_write_data,
    output logic                     sel_d1,
    output logic [31:0]              rd_data,
    output logic                     TXD,
    output logic                     tx_active,
    output logic                     irq
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(DATA_BITS);

    logic                 hit, wr_lo, push_req, ovf_clr, flush, baud_we, pop, start_ok, stop_last;
    logic [1:0]           off;
    logic [DATA_BITS-1:0] f_rdata, shreg;
    logic [AW:0]          f_count;
    logic                 f_full, f_empty;
    logic [BAUD_BITS-1:0] baud_reg, baud_lat, baud_cnt;
    logic                 ctrl_en, ctrl_stop2, stop2_lat, ovf;
    logic [BCW-1:0]       bit_cnt;
    logic [31:0]          status, rd_mux;
    tx_state_t            state;
    logic                 unused_bits;

    assign hit      = (mem_addr[MEM_ADDR_BITS-1:2] == BASE_WADDR[MEM_ADDR_BITS-1:2]);
    assign off      = mem_addr[1:0];
    assign wr_lo    = hit && mem_write_en[0];
    assign push_req = wr_lo && (off == OFF_DATA);
    assign ovf_clr  = wr_lo && (off == OFF_STATUS) && mem_write_data[ST_OVF];
    assign flush    = (wr_lo && (off == OFF_CTRL) && mem_write_data[CT_FLUSH]) || sync_reset;
    assign baud_we  = hit && (off == OFF_BAUD);
    assign unused_bits = ^{mem_write_en[3:2], mem_write_data[31:16]};

    // A frame starts from IDLE, or back-to-back as the final stop bit expires.
    assign start_ok  = ctrl_en && !f_empty;
    assign stop_last = (bit_cnt == BCW'(stop2_lat));
    assign pop = start_ok && ((state == TX_IDLE) ||
                              (state == TX_STOP && baud_cnt == '0 && stop_last));

    rv2t_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push_req),
        .wdata (mem_write_data[DATA_BITS-1:0]),
        .pop   (pop),
        .rdata (f_rdata),
        .count (f_count),
        .full  (f_full),
        .empty (f_empty)
    );

    always_comb begin
        status = '0;
        status[ST_ACTIVE] = tx_active;
        status[ST_FULL]   = f_full;
        status[ST_EMPTY]  = f_empty;
        status[ST_OVF]    = ovf;
        status[ST_CNT_LSB +: 8] = 8'(f_count);
        case (off)
            OFF_STATUS: rd_mux = status;
            OFF_BAUD:   rd_mux = 32'(baud_reg);
            OFF_CTRL:   rd_mux = {29'd0, ctrl_stop2, 1'b0, ctrl_en};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || sync_reset) begin
            sel_d1     <= 1'b0;
            rd_data    <= '0;
            baud_reg   <= DEFAULT_BAUD_M1;
            ctrl_en    <= 1'b1;
            ctrl_stop2 <= 1'b0;
            ovf        <= 1'b0;
            irq        <= 1'b1;
        end else begin
            sel_d1  <= hit;
            rd_data <= hit ? rd_mux : '0;
            for (int i = 0; i < BAUD_BITS; i++) begin
                if (i < 16 && baud_we && mem_write_en[i/8]) baud_reg[i] <= mem_write_data[i];
            end
            if (wr_lo && off == OFF_CTRL) begin
                ctrl_en    <= mem_write_data[CT_EN];
                ctrl_stop2 <= mem_write_data[CT_STOP2];
            end
            if (push_req && f_full && !pop) ovf <= 1'b1;
            else if (ovf_clr)               ovf <= 1'b0;
            irq <= f_empty && ctrl_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || sync_reset) begin
            state     <= TX_IDLE;
            TXD       <= 1'b1;
            tx_active <= 1'b0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            baud_lat  <= '0;
            stop2_lat <= 1'b0;
            shreg     <= '0;
        end else if (pop) begin
            state     <= TX_START;
            TXD       <= 1'b0;
            tx_active <= 1'b1;
            bit_cnt   <= '0;
            baud_cnt  <= baud_reg;
            baud_lat  <= baud_reg;
            stop2_lat <= ctrl_stop2;
            shreg     <= f_rdata;
        end else if (state != TX_IDLE) begin
            if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - BAUD_BITS'(1);
            end else begin
                baud_cnt <= baud_lat;
                case (state)
                    TX_START: begin
                        state <= TX_DATA;
                        TXD   <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    TX_DATA: begin
                        if (bit_cnt == BCW'(DATA_BITS-1)) begin
                            state   <= TX_STOP;
                            TXD     <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            TXD     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                    TX_STOP: begin
                        if (stop_last) begin
                            state     <= TX_IDLE;
                            tx_active <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                    default: state <= TX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv2t_uart_tx_mmio.sv
// Directed bench for rv2t_uart_tx_mmio with hand-computed frame patterns.
module tb_rv2t_uart_tx_mmio;

    localparam logic [13:0] BASE = 14'h3FF0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sync_reset = 1'b0;
    logic [13:0] mem_addr = '0;
    logic [3:0]  mem_write_en = '0;
    logic [31:0] mem_write_data = '0;
    logic        sel_d1, TXD, tx_active, irq;
    logic [31:0] rd_data;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int c0;

    rv2t_uart_tx_mmio dut (
        .clk            (clk),
        .reset          (reset),
        .sync_reset     (sync_reset),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .sel_d1         (sel_d1),
        .rd_data        (rd_data),
        .TXD            (TXD),
        .tx_active      (tx_active),
        .irq            (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        @(negedge clk);
        mem_addr       = BASE | {12'd0, off};
        mem_write_en   = 4'b0011;
        mem_write_data = d;
        @(negedge clk);
        mem_write_en   = '0;
        mem_write_data = '0;
        mem_addr       = '0;
    endtask

    task automatic rd(input string tag, input logic [1:0] off, input logic [31:0] exp);
        @(negedge clk);
        mem_addr = BASE | {12'd0, off};
        @(negedge clk);
        chk1({tag, ".sel"}, sel_d1, 1'b1);
        chk(tag, rd_data, exp);
        mem_addr = '0;
    endtask

    // Frame checker: pattern bit i is the expected line level of bit period i.
    task automatic frame(input string tag, input logic [31:0] pat, input int nbits, input int per);
        for (int k = 0; k < nbits * per; k++) begin
            @(negedge clk);
            chk1({tag, ".txd"}, TXD, pat[k / per]);
            chk1({tag, ".act"}, tx_active, 1'b1);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk1("rst.txd", TXD, 1'b1);
        chk1("rst.act", tx_active, 1'b0);
        chk1("rst.sel", sel_d1, 1'b0);
        chk("rst.rd", rd_data, 32'h0);
        chk1("rst.irq", irq, 1'b1);
        reset = 1'b0;
        rd("rst.status", 2'd1, 32'h0000_0004);
        rd("rst.baud", 2'd2, 32'd867);
        rd("rst.ctrl", 2'd3, 32'h1);
        rd("data.rd0", 2'd0, 32'h0);
        @(negedge clk);
        chk1("idle.sel", sel_d1, 1'b0);
        chk("idle.rd", rd_data, 32'h0);

        // 0x55, BAUD=3, one stop bit
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h55);
        frame("f55", 32'h2AA, 10, 4);
        @(negedge clk);
        chk1("f55.end.act", tx_active, 1'b0);
        chk1("f55.end.txd", TXD, 1'b1);

        // overflow with TX disabled
        wr(2'd3, 32'h0);
        for (int i = 0; i < 9; i++) wr(2'd0, 32'(i));
        rd("ovf.status", 2'd1, 32'h0000_080A);
        chk1("ovf.irq", irq, 1'b0);
        wr(2'd1, 32'h8);
        rd("ovf.clr", 2'd1, 32'h0000_0802);
        wr(2'd3, 32'h2);
        rd("ovf.flush", 2'd1, 32'h0000_0004);
        wr(2'd3, 32'h1);
        chk1("irq.lag", irq, 1'b0);
        @(negedge clk);
        chk1("irq.on", irq, 1'b1);

        // back-to-back 0x41, 0x42 at BAUD=1
        wr(2'd3, 32'h0);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h41);
        wr(2'd0, 32'h42);
        wr(2'd3, 32'h1);
        for (int k = 0; k < 40; k++) begin
            logic [31:0] p;
            p = 32'h000A_1282;
            @(negedge clk);
            chk1("b2b.txd", TXD, p[k / 2]);
            chk1("b2b.act", tx_active, 1'b1);
            chk1("b2b.irq", irq, k >= 21);
        end
        @(negedge clk);
        chk1("b2b.end", tx_active, 1'b0);

        // two stop bits, 0xFF at BAUD=0
        wr(2'd2, 32'd0);
        wr(2'd3, 32'h5);
        wr(2'd0, 32'hFF);
        frame("stop2", 32'h7FE, 11, 1);
        @(negedge clk);
        chk1("stop2.end", tx_active, 1'b0);

        // flush during the first of three queued frames
        wr(2'd3, 32'h0);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        wr(2'd0, 32'h33);
        wr(2'd3, 32'h1);
        @(negedge clk);
        chk1("fl.start", TXD, 1'b0);
        c0 = cyc;
        wr(2'd3, 32'h3);
        rd("fl.status", 2'd1, 32'h0000_0005);
        for (int i = 0; i < 100 && tx_active; i++) @(negedge clk);
        chk1("fl.done", tx_active, 1'b0);
        chk("fl.len", 32'(cyc - c0), 32'd20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("fl.idle.txd", TXD, 1'b1);
            chk1("fl.idle.act", tx_active, 1'b0);
        end
        rd("fl.status2", 2'd1, 32'h0000_0004);
        rd("fl.ctrl", 2'd3, 32'h1);

        // async reset in the middle of DATA
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h00);
        mem_addr = BASE | 14'd2;
        repeat (12) @(negedge clk);
        chk1("mr.txd", TXD, 1'b0);
        chk1("mr.act", tx_active, 1'b1);
        chk("mr.rd", rd_data, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk1("mr.rst.txd", TXD, 1'b1);
        chk1("mr.rst.act", tx_active, 1'b0);
        chk1("mr.rst.sel", sel_d1, 1'b0);
        chk("mr.rst.rd", rd_data, 32'h0);
        chk1("mr.rst.irq", irq, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_addr = '0;
        rd("mr.baud", 2'd2, 32'd867);
        rd("mr.status", 2'd1, 32'h0000_0004);

        // synchronous reset restores defaults
        wr(2'd2, 32'd5);
        wr(2'd3, 32'h4);
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        rd("sr.baud", 2'd2, 32'd867);
        rd("sr.ctrl", 2'd3, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
